led_sequencer: RTL

LED_SEQUENCER -- requirements
Module: led_sequencer

---
 rtl/led_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// Steps a colour value through the range [MIN_VAL, MAX_VAL], either one step
// per button press (manual) or one step every AUTO_DIV clocks (auto). In auto,
// a button press pauses and resumes the stepping. The sequence wraps at the
// ends of the range in the selected direction and flags each wrap.
//
// Parameters
//   WIDTH     colour bus width
//   MIN_VAL   lowest legal sequence value  (1 <= MIN_VAL <= MAX_VAL)
//   MAX_VAL   highest legal sequence value (MAX_VAL <= 2^WIDTH-1)
//   AUTO_DIV  clock cycles per automatic step (>= 1)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous, active-high reset
//   button     in   step request, level; rising edge is detected internally
//   dir        in   0 = ascending, 1 = descending; sampled on step edges only
//   auto_mode  in   1 = self-stepping from prescaler, 0 = manual stepping
//   colour     out  current sequence value (0 while OFF), registered
//   wrap       out  one-cycle pulse on the edge where colour wraps
//   paused     out  high while auto stepping is suspended, registered
// -----------------------------------------------------------------------------
module led_sequencer #(
    parameter int WIDTH    = 3,
    parameter int MIN_VAL  = 1,
    parameter int MAX_VAL  = 6,
    parameter int AUTO_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic             dir,
    input  logic             auto_mode,
    output logic [WIDTH-1:0] colour,
    output logic             wrap,
    output logic             paused
);

    localparam int PRE_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    localparam logic [WIDTH-1:0] MIN_C  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(AUTO_DIV - 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_MANUAL = 2'd1,
        S_AUTO   = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] colour_q;
    logic             wrap_q;
    logic             paused_q;
    logic [PRE_W-1:0] pre_q;
    logic             btn_q;

    logic             btn_edge;
    logic             pre_tc;
    logic [WIDTH-1:0] step_val_d;
    logic             step_wrap_d;

    // Next value of a single step, returned as {wrap, value}. An out-of-range
    // current value (including the 0 held while OFF) reloads the start of the
    // range for the chosen direction without flagging a wrap. With a one-value
    // range, the "at end" test matches every step, so colour stays put and
    // every step wraps.
    function automatic logic [WIDTH:0] step_fn(input logic [WIDTH-1:0] cur,
                                               input logic             down);
        logic [WIDTH:0] res;
        if ((cur < MIN_C) || (cur > MAX_C)) begin
            res = {1'b0, (down ? MAX_C : MIN_C)};
        end else if (!down) begin
            res = (cur == MAX_C) ? {1'b1, MIN_C} : {1'b0, cur + WIDTH'(1)};
        end else begin
            res = (cur == MIN_C) ? {1'b1, MAX_C} : {1'b0, cur - WIDTH'(1)};
        end
        return res;
    endfunction

    always_comb begin
        btn_edge                  = button & ~btn_q;
        pre_tc                    = (pre_q == PRE_TC);
        {step_wrap_d, step_val_d} = step_fn(colour_q, dir);
    end

    // Mode changes are tested before btn_edge in every state, so a button edge
    // arriving together with an auto_mode change is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_OFF;
            colour_q <= '0;
            wrap_q   <= 1'b0;
            paused_q <= 1'b0;
            pre_q    <= '0;
            // Starts high so a button held through reset release is not an edge.
            btn_q    <= 1'b1;
        end else begin
            btn_q    <= button;
            wrap_q   <= 1'b0;
            paused_q <= 1'b0;

            unique case (state_q)
                S_OFF: begin
                    if (auto_mode) begin
                        // The prescaler terminal count is the first step event.
                        if (pre_tc) begin
                            colour_q <= step_val_d;
                            pre_q    <= '0;
                            state_q  <= S_AUTO;
                        end else begin
                            pre_q <= pre_q + PRE_W'(1);
                        end
                    end else begin
                        pre_q <= '0;
                        if (btn_edge) begin
                            colour_q <= step_val_d;
                            state_q  <= S_MANUAL;
                        end
                    end
                end

                S_MANUAL: begin
                    pre_q <= '0;
                    if (auto_mode) begin
                        state_q <= S_AUTO;
                    end else if (btn_edge) begin
                        colour_q <= step_val_d;
                        wrap_q   <= step_wrap_d;
                    end
                end

                S_AUTO: begin
                    if (!auto_mode) begin
                        pre_q   <= '0;
                        state_q <= S_MANUAL;
                    end else if (btn_edge) begin
                        // Freeze here; the prescaler value is kept but is
                        // restarted on resume anyway.
                        paused_q <= 1'b1;
                        state_q  <= S_PAUSED;
                    end else if (pre_tc) begin
                        colour_q <= step_val_d;
                        wrap_q   <= step_wrap_d;
                        pre_q    <= '0;
                    end else begin
                        pre_q <= pre_q + PRE_W'(1);
                    end
                end

                S_PAUSED: begin
                    if (!auto_mode) begin
                        pre_q   <= '0;
                        state_q <= S_MANUAL;
                    end else if (btn_edge) begin
                        pre_q   <= '0;
                        state_q <= S_AUTO;
                    end else begin
                        paused_q <= 1'b1;
                    end
                end

                default: begin
                    pre_q   <= '0;
                    state_q <= S_OFF;
                end
            endcase
        end
    end

    assign colour = colour_q;
    assign wrap   = wrap_q;
    assign paused = paused_q;

endmodule
